// File: rtl/pwm_pkg.sv
// pwm_pkg: types and constants shared by the PWM generator and capture blocks
package pwm_pkg;
  typedef enum logic [1:0] {IDLE, MEASURE, DIVIDE} pwm_state_t;
  localparam int DUTY_STEPS_DEF = 10;
endpackage

// File: rtl/pwm_capture_if.sv
// pwm_capture_if: PWM input line plus the measurement results of pwm_capture
interface pwm_capture_if #(parameter int CNT_W = 16, parameter int QW = 4);
  logic pwm_in;
  logic [CNT_W-1:0] period_out, high_out;
  logic [QW-1:0] duty_out;
  logic meas_valid, stuck, overrun;
  modport master(input pwm_in, output period_out, high_out, duty_out, meas_valid, stuck, overrun);
  modport slave(output pwm_in, input period_out, high_out, duty_out, meas_valid, stuck, overrun);
endinterface

// File: rtl/pwm_duty_div.sv
// pwm_duty_div: restoring divider, one quotient bit per cycle MSB first, QW cycles per divide
module pwm_duty_div #(
  parameter int NW = 20,
  parameter int DW = 16,
  parameter int QW = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [NW-1:0] numerator,
  input  logic [DW-1:0] divisor,
  output logic busy,
  output logic done,
  output logic [QW-1:0] quotient
);
  localparam int CW = $clog2(QW + 1);
  logic [NW-1:0] rem, dsh;
  logic [QW-1:0] q;
  logic [CW-1:0] cnt;
  logic qbit;
  assign qbit = rem >= dsh;
  assign done = busy && cnt == CW'(QW - 1);
  assign quotient = (q << 1) | QW'(qbit);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      busy <= 1'b0;
      rem <= '0;
      dsh <= '0;
      q <= '0;
      cnt <= '0;
    end else if (start) begin
      busy <= 1'b1;
      rem <= numerator;
      dsh <= NW'(divisor) << (QW - 1);
      q <= '0;
      cnt <= '0;
    end else if (busy) begin
      busy <= !done;
      rem <= qbit ? rem - dsh : rem;
      dsh <= dsh >> 1;
      q <= quotient;
      cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures period, high time and quantised duty of an asynchronous PWM input.
// Define PWM_CAPTURE_FILTER_EN to add a FILT_LEN-cycle glitch filter after the synchroniser.
module pwm_capture import pwm_pkg::*; #(
  parameter int CNT_W = 16,
  parameter int DUTY_STEPS = DUTY_STEPS_DEF,
  parameter int QW = 4,
  parameter int TIMEOUT = 1000,
  parameter int FILT_LEN = 3
) (
  input logic clk,
  input logic rst,
  pwm_capture_if.master bus
);
  localparam int NW = CNT_W + QW;
  pwm_state_t state, state_nx;
  logic s1, pwm_s, lvl, lvl_d, rise, timeout;
  logic div_start, take, fire, ovr, div_busy, div_done;
  logic [CNT_W-1:0] period_cnt, high_cnt, p_snap, h_snap;
  logic [QW-1:0] quotient;
  if ((1 << QW) <= DUTY_STEPS || TIMEOUT >= (1 << CNT_W) || FILT_LEN < 1) begin : g_bad_cfg
    $error("pwm_capture: inconsistent parameters");
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) {s1, pwm_s} <= 2'b00;
    else {s1, pwm_s} <= {bus.pwm_in, s1};
`ifdef PWM_CAPTURE_FILTER_EN
  localparam int FW = $clog2(FILT_LEN + 1);
  logic [FW-1:0] stable;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lvl <= 1'b0;
      stable <= '0;
    end else if (pwm_s == lvl) stable <= '0;
    else if (stable == FW'(FILT_LEN - 1)) begin
      lvl <= pwm_s;
      stable <= '0;
    end else stable <= stable + FW'(1);
`else
  assign lvl = pwm_s;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) lvl_d <= 1'b0;
    else lvl_d <= lvl;
  assign rise = lvl & ~lvl_d;
  // A rise always wins over a timeout in the same cycle; DIVIDE never times out.
  assign timeout = !rise && state != DIVIDE && period_cnt >= CNT_W'(TIMEOUT);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (rise ? MEASURE : IDLE) :
               state == MEASURE ? (rise ? DIVIDE : timeout ? IDLE : MEASURE) :
               (div_done ? MEASURE : DIVIDE);
  always_comb begin
    div_start = state == MEASURE && rise;
    take = state == DIVIDE && div_done;
    ovr = rise && div_busy;
    fire = timeout && !bus.stuck;
  end
  // Counters freeze at TIMEOUT so a stuck line can never wrap them.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      period_cnt <= '0;
      high_cnt <= '0;
    end else if (rise) begin
      period_cnt <= CNT_W'(1);
      high_cnt <= CNT_W'(1);
    end else if (state != IDLE && !timeout) begin
      period_cnt <= period_cnt + CNT_W'(1);
      high_cnt <= high_cnt + CNT_W'(lvl);
    end
  pwm_duty_div #(.NW(NW), .DW(CNT_W), .QW(QW)) u_div (
    .clk(clk),
    .rst(rst),
    .start(div_start),
    .numerator(NW'(high_cnt) * NW'(DUTY_STEPS)),
    .divisor(period_cnt),
    .busy(div_busy),
    .done(div_done),
    .quotient(quotient)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      p_snap <= '0;
      h_snap <= '0;
      bus.period_out <= '0;
      bus.high_out <= '0;
      bus.duty_out <= '0;
      bus.meas_valid <= 1'b0;
      bus.stuck <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      if (div_start) begin
        p_snap <= period_cnt;
        h_snap <= high_cnt;
      end
      bus.meas_valid <= take || fire;
      bus.overrun <= ovr;
      if (take) begin
        bus.period_out <= p_snap;
        bus.high_out <= h_snap;
        bus.duty_out <= quotient;
        bus.stuck <= 1'b0;
      end else if (fire) begin
        bus.period_out <= '0;
        bus.high_out <= '0;
        bus.duty_out <= lvl ? QW'(DUTY_STEPS) : '0;
        bus.stuck <= 1'b1;
      end
    end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: random and directed PWM waveforms checked against a period/high/duty scoreboard
module tb_pwm_capture;
  localparam int CNT_W = 16, QW = 4, DUTY = 10, TMO = 1000;
  typedef struct {int p; int h; int d; int st; int t;} exp_t;
  logic clk = 1'b0, rst = 1'b1;
  int cyc = 0, checks = 0, errors = 0, ovr_exp = 0, ovr_seen = 0;
  exp_t q[$];
  bit armed, stuck_m, prev;
  int last, s_start, hi;
  pwm_capture_if #(.CNT_W(CNT_W), .QW(QW)) bus();
  pwm_capture #(.CNT_W(CNT_W), .DUTY_STEPS(DUTY), .QW(QW), .TIMEOUT(TMO), .FILT_LEN(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // Reference: measure the driven waveform edge to edge; the synchroniser only adds a fixed delay.
  task automatic step(input bit v);
    int c;
    c = cyc;
    if (v && !prev) begin
      if (!armed) armed = 1'b1;
      else if (c - s_start <= QW) ovr_exp++;
      else begin
        q.push_back('{p: c - last, h: hi, d: hi * DUTY / (c - last), st: 0, t: c + QW + 3});
        stuck_m = 1'b0;
        s_start = c;
      end
      last = c;
      hi = 0;
    end else if (armed && c - last == TMO) begin
      if (!stuck_m) q.push_back('{p: 0, h: 0, d: v ? DUTY : 0, st: 1, t: c + 3});
      stuck_m = 1'b1;
      armed = 1'b0;
    end
    hi += int'(v);
    prev = v;
  endtask
  task automatic drive(input bit v);
    @(posedge clk);
    #1 bus.pwm_in = v;
    step(v);
  endtask
  task automatic wave(input int p, input int h, input int n);
    repeat (n) for (int i = 0; i < p; i++) drive(i < h);
  endtask
  task automatic hold(input bit v, input int n);
    repeat (n) drive(v);
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    bus.pwm_in = 1'b0;
    armed = 1'b0;
    stuck_m = 1'b0;
    prev = 1'b0;
    s_start = -100000;
    last = 0;
    hi = 0;
    q.delete();
    #1;
    check("rst_period", int'(bus.period_out), 0);
    check("rst_high", int'(bus.high_out), 0);
    check("rst_duty", int'(bus.duty_out), 0);
    check("rst_valid", int'(bus.meas_valid), 0);
    check("rst_stuck", int'(bus.stuck), 0);
    check("rst_overrun", int'(bus.overrun), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (bus.overrun) ovr_seen++;
      if (bus.meas_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: period=%0d high=%0d duty=%0d at cycle %0d with no result due",
                   bus.period_out, bus.high_out, bus.duty_out, cyc);
        end else begin
          e = q.pop_front();
          check("period", int'(bus.period_out), e.p);
          check("high", int'(bus.high_out), e.h);
          check("duty", int'(bus.duty_out), e.d);
          check("stuck", int'(bus.stuck), e.st);
          check("latency", cyc, e.t);
        end
      end
    end
  end
  initial begin
    bus.pwm_in = 1'b0;
    do_reset();
    wave(10, 5, 6);
    for (int h = 1; h <= 9; h++) wave(10, h, 3);
    hold(1'b0, 1100);
    wave(10, 5, 3);
    hold(1'b1, 1100);
    wave(10, 5, 3);
    wave(7, 3, 4);
    wave(4, 2, 6);
    wave(10, 5, 4);
    drive(1'b1);
    drive(1'b1);
    drive(1'b1);
    do_reset();
    wave(10, 5, 4);
    repeat (150) begin
      int p, h;
      if ($urandom_range(0, 39) == 0) hold(1'($urandom_range(0, 1)), 1100);
      p = ($urandom_range(0, 4) == 0) ? $urandom_range(2, 6) : $urandom_range(2, 40);
      h = $urandom_range(1, p - 1);
      wave(p, h, $urandom_range(1, 4));
    end
    hold(1'b0, 1100);
    repeat (10) @(posedge clk);
    check("pending_results", q.size(), 0);
    check("overrun_count", ovr_seen, ovr_exp);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
